// File: rtl/pix_cmp_pkg.sv
// Shared types and constants for the pixel comparison controller.
package pix_cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DIM_W_DEF = 12;
  localparam int ACC_W_DEF = 40;

  // RGB888 channel slices within a 24-bit pixel
  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

endpackage

// File: rtl/pix_sqdiff.sv
// One colour channel: registered squared difference of two 8-bit samples.
// With PIX_CMP_MAX_ERR_EN defined, the registered magnitude |a-b| is also output.
module pix_sqdiff (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
`ifdef PIX_CMP_MAX_ERR_EN
  output logic [7:0]  mag,
`endif
  output logic [15:0] sq
);

  logic [7:0] mag_c;

  // |a-b| squared equals the signed 9-bit difference squared, and keeps the multiply unsigned
  assign mag_c = (a >= b) ? (a - b) : (b - a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq <= '0;
`ifdef PIX_CMP_MAX_ERR_EN
      mag <= '0;
`endif
    end else if (load) begin
      sq <= {8'd0, mag_c} * {8'd0, mag_c};
`ifdef PIX_CMP_MAX_ERR_EN
      mag <= mag_c;
`endif
    end
  end

endmodule

// File: rtl/pix_cmp_ctrl.sv
// Frame comparator: streams width*height pixel pairs and sums squared RGB differences.
// Optional per-channel max |diff| outputs are enabled by defining PIX_CMP_MAX_ERR_EN.
module pix_cmp_ctrl
  import pix_cmp_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  output logic               rd_req,
  output logic [2*DIM_W-1:0] rd_addr,
  input  logic               rd_gnt,
  input  logic               rd_vld,
  input  logic [23:0]        pix_a,
  input  logic [23:0]        pix_b,
  output logic               busy,
  output logic               done,
`ifdef PIX_CMP_MAX_ERR_EN
  output logic [7:0]         max_r,
  output logic [7:0]         max_g,
  output logic [7:0]         max_b,
`endif
  output logic [ACC_W-1:0]   sum_r,
  output logic [ACC_W-1:0]   sum_g,
  output logic [ACC_W-1:0]   sum_b
);

  localparam int AW = 2 * DIM_W;
  localparam logic [AW-1:0] ONE_A = 1;
  localparam logic [AW:0]   ONE_O = 1;

  state_t           state;
  logic [DIM_W-1:0] w_lat;
  logic [DIM_W-1:0] h_lat;
  logic [AW-1:0]    last_idx;
  logic [AW:0]      outst;
  logic             grant;
  logic             vld_ok;
  logic             start_acc;
  logic             sq_vld;
  logic [15:0]      sq_r;
  logic [15:0]      sq_g;
  logic [15:0]      sq_b;
`ifdef PIX_CMP_MAX_ERR_EN
  logic [7:0]       mag_r;
  logic [7:0]       mag_g;
  logic [7:0]       mag_b;
`endif

  assign last_idx  = ({{DIM_W{1'b0}}, w_lat} * {{DIM_W{1'b0}}, h_lat}) - ONE_A;
  assign grant     = rd_req && rd_gnt;
  assign vld_ok    = rd_vld && (state == S_ISSUE || state == S_DRAIN);
  assign start_acc = start && (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_lat   <= '0;
      h_lat   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            w_lat   <= width;
            h_lat   <= height;
            rd_addr <= '0;
            if (width == '0 || height == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_ISSUE;
              rd_req <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (grant) begin
            if (rd_addr == last_idx) begin
              rd_req <= 1'b0;
              state  <= S_DRAIN;
            end else begin
              rd_addr <= rd_addr + ONE_A;
            end
          end
        end
        S_DRAIN: begin
          // The final square still in the pipe register is summed on this same edge.
          if (outst == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= '0;
    end else if (start_acc) begin
      outst <= '0;
    end else if (grant && !vld_ok) begin
      outst <= outst + ONE_O;
    end else if (!grant && vld_ok) begin
      outst <= outst - ONE_O;
    end
  end

  pix_sqdiff u_sq_r (
    .clk  (clk),
    .rst  (rst),
    .load (vld_ok),
    .a    (pix_a[R_HI:R_LO]),
    .b    (pix_b[R_HI:R_LO]),
`ifdef PIX_CMP_MAX_ERR_EN
    .mag  (mag_r),
`endif
    .sq   (sq_r)
  );

  pix_sqdiff u_sq_g (
    .clk  (clk),
    .rst  (rst),
    .load (vld_ok),
    .a    (pix_a[G_HI:G_LO]),
    .b    (pix_b[G_HI:G_LO]),
`ifdef PIX_CMP_MAX_ERR_EN
    .mag  (mag_g),
`endif
    .sq   (sq_g)
  );

  pix_sqdiff u_sq_b (
    .clk  (clk),
    .rst  (rst),
    .load (vld_ok),
    .a    (pix_a[B_HI:B_LO]),
    .b    (pix_b[B_HI:B_LO]),
`ifdef PIX_CMP_MAX_ERR_EN
    .mag  (mag_b),
`endif
    .sq   (sq_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_vld <= 1'b0;
      sum_r  <= '0;
      sum_g  <= '0;
      sum_b  <= '0;
    end else begin
      sq_vld <= vld_ok;
      if (start_acc) begin
        sum_r <= '0;
        sum_g <= '0;
        sum_b <= '0;
      end else if (sq_vld) begin
        sum_r <= sum_r + {{(ACC_W-16){1'b0}}, sq_r};
        sum_g <= sum_g + {{(ACC_W-16){1'b0}}, sq_g};
        sum_b <= sum_b + {{(ACC_W-16){1'b0}}, sq_b};
      end
    end
  end

`ifdef PIX_CMP_MAX_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_r <= '0;
      max_g <= '0;
      max_b <= '0;
    end else if (start_acc) begin
      max_r <= '0;
      max_g <= '0;
      max_b <= '0;
    end else if (sq_vld) begin
      if (mag_r > max_r) max_r <= mag_r;
      if (mag_g > max_g) max_g <= mag_g;
      if (mag_b > max_b) max_b <= mag_b;
    end
  end
`endif

endmodule

// File: tb/tb_pix_cmp_ctrl.sv
// Self-checking bench for pix_cmp_ctrl with a randomized grant/return memory responder.
module tb_pix_cmp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] width = '0;
  logic [11:0] height = '0;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_gnt = 1'b0;
  logic        rd_vld = 1'b0;
  logic [23:0] pix_a = '0;
  logic [23:0] pix_b = '0;
  logic        busy;
  logic        done;
  logic [39:0] sum_r, sum_g, sum_b;
`ifdef PIX_CMP_MAX_ERR_EN
  logic [7:0]  max_r, max_g, max_b;
`endif

  pix_cmp_ctrl #(.DIM_W(12), .ACC_W(40)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .width   (width),
    .height  (height),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_gnt  (rd_gnt),
    .rd_vld  (rd_vld),
    .pix_a   (pix_a),
    .pix_b   (pix_b),
    .busy    (busy),
    .done    (done),
`ifdef PIX_CMP_MAX_ERR_EN
    .max_r   (max_r),
    .max_g   (max_g),
    .max_b   (max_b),
`endif
    .sum_r   (sum_r),
    .sum_g   (sum_g),
    .sum_b   (sum_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int req_cycles = 0;
  bit gnt_rand = 1'b0;
  bit inject = 1'b0;
  int lat_max = 1;
  logic [23:0] pa [0:255];
  logic [23:0] pb [0:255];
  int q_addr[$];
  int q_rdy[$];
  int addr_log[$];

  always @(posedge clk) cyc++;

  // Memory responder and output monitor; everything changes mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_rdy.delete();
      rd_gnt = 1'b0;
      rd_vld = 1'b0;
    end else begin
      rd_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_req) req_cycles++;
      if (rd_req && rd_gnt) begin
        addr_log.push_back(int'(rd_addr));
        q_addr.push_back(int'(rd_addr));
        q_rdy.push_back(cyc + int'($urandom_range(1, lat_max)));
      end
      rd_vld = 1'b0;
      if (inject) begin
        rd_vld = 1'b1;
        pix_a  = 24'hFFFFFF;
        pix_b  = 24'h000000;
      end else if (q_rdy.size() > 0 && q_rdy[0] <= cyc) begin
        rd_vld = 1'b1;
        pix_a  = pa[q_addr[0] & 255];
        pix_b  = pb[q_addr[0] & 255];
        void'(q_addr.pop_front());
        void'(q_rdy.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [39:0] chan_sum(int n, int sh);
    logic [39:0] s = '0;
    for (int i = 0; i < n; i++) begin
      int da = int'((pa[i] >> sh) & 24'hFF);
      int db = int'((pb[i] >> sh) & 24'hFF);
      s += 40'((da - db) * (da - db));
    end
    return s;
  endfunction

  function automatic logic [119:0] model(int n);
    return {chan_sum(n, 16), chan_sum(n, 8), chan_sum(n, 0)};
  endfunction

  task automatic run_frame(input int w, input int h, input bit mid, output bit ok,
                           output int lat, output int ndone, output int nreq);
    int st, d0, r0;
    @(negedge clk);
    addr_log.delete();
    width = 12'(w);
    height = 12'(h);
    start = 1'b1;
    st = cyc;
    d0 = done_cnt;
    r0 = req_cycles;
    @(negedge clk);
    start = 1'b0;
    if (mid) begin
      repeat (2) @(negedge clk);
      width = 12'd0;
      height = 12'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    lat = done_cyc - st;
    repeat (3) @(negedge clk);
    ndone = done_cnt - d0;
    nreq = req_cycles - r0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    if ({rd_req, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctl: req/busy/done=%b want 000", {rd_req, busy, done});
    end
    n_cmp++;
    if (rd_addr !== 24'd0) begin
      n_err++; $display("FAIL reset_addr: got %0d want 0", rd_addr);
    end
    n_cmp++;
    if ({sum_r, sum_g, sum_b} !== 120'd0) begin
      n_err++; $display("FAIL reset_sums: got %0d/%0d/%0d want 0", sum_r, sum_g, sum_b);
    end
    n_cmp++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int lat, nd, nr; bit bad;
    gnt_rand = 1'b0; lat_max = 1;
    for (int i = 0; i < 4; i++) begin pa[i] = 24'hFFFFFF; pb[i] = 24'h000000; end
    run_frame(2, 2, 1'b0, ok, lat, nd, nr);
    if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: done not seen"); end
    n_cmp++;
    if ({sum_r, sum_g, sum_b} !== {3{40'd260100}}) begin
      n_err++; $display("FAIL basic_sums: got %0d/%0d/%0d want 260100 each", sum_r, sum_g, sum_b);
    end
    n_cmp++;
    if (lat !== 7) begin n_err++; $display("FAIL basic_latency: got %0d want 7", lat); end
    n_cmp++;
    if (nd !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    n_cmp++;
    bad = (addr_log.size() != 4);
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) bad = 1'b1;
    if (bad !== 1'b0) begin
      n_err++; $display("FAIL basic_addr_seq: %0d addresses, gap/repeat present, want 0..3", addr_log.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    n_cmp++;
  endtask

  task automatic test_zero_dim();
    bit ok; int lat, nd, nr;
    run_frame(0, 5, 1'b0, ok, lat, nd, nr);
    if (ok !== 1'b1) begin n_err++; $display("FAIL zero_timeout: done not seen"); end
    n_cmp++;
    if (nr !== 0) begin n_err++; $display("FAIL zero_no_req: %0d request cycles want 0", nr); end
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_cmp++;
    if ({sum_r, sum_g, sum_b} !== 120'd0) begin
      n_err++; $display("FAIL zero_sums: got %0d/%0d/%0d want 0", sum_r, sum_g, sum_b);
    end
    n_cmp++;
  endtask

  task automatic test_identical();
    bit ok; int lat, nd, nr;
    gnt_rand = 1'b0; lat_max = 1;
    for (int i = 0; i < 12; i++) begin pa[i] = 24'($urandom); pb[i] = pa[i]; end
    run_frame(4, 3, 1'b0, ok, lat, nd, nr);
    if ({sum_r, sum_g, sum_b} !== 120'd0) begin
      n_err++; $display("FAIL ident_sums: got %0d/%0d/%0d want 0", sum_r, sum_g, sum_b);
    end
    n_cmp++;
    if (nd !== 1) begin n_err++; $display("FAIL ident_done_count: got %0d want 1", nd); end
    n_cmp++;
  endtask

  task automatic test_random();
    bit ok; int lat, nd, nr; bit bad; int w, h;
    logic [119:0] exp;
    gnt_rand = 1'b1; lat_max = 8;
    for (int f = 0; f < 6; f++) begin
      w = int'($urandom_range(1, 6));
      h = int'($urandom_range(1, 6));
      for (int i = 0; i < w * h; i++) begin pa[i] = 24'($urandom); pb[i] = 24'($urandom); end
      exp = model(w * h);
      run_frame(w, h, (w * h >= 4), ok, lat, nd, nr);
      if (ok !== 1'b1) begin n_err++; $display("FAIL rand_timeout: frame %0d done not seen", f); end
      n_cmp++;
      if ({sum_r, sum_g, sum_b} !== exp) begin
        n_err++;
        $display("FAIL rand_sums: frame %0d %0dx%0d got %0d/%0d/%0d want %0d/%0d/%0d", f, w, h,
                 sum_r, sum_g, sum_b, exp[119:80], exp[79:40], exp[39:0]);
      end
      n_cmp++;
      bad = (addr_log.size() != w * h);
      for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) bad = 1'b1;
      if (bad !== 1'b0) begin
        n_err++; $display("FAIL rand_addr_seq: frame %0d got %0d addresses want 0..%0d", f, addr_log.size(), w * h - 1);
      end
      n_cmp++;
      if (nd !== 1) begin n_err++; $display("FAIL rand_done_count: frame %0d got %0d want 1", f, nd); end
      n_cmp++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int lat, nd, nr;
    logic [119:0] exp;
    gnt_rand = 1'b0; lat_max = 3;
    for (int i = 0; i < 6; i++) begin pa[i] = 24'($urandom); pb[i] = 24'($urandom); end
    exp = model(6);
    run_frame(3, 2, 1'b1, ok, lat, nd, nr);
    if ({sum_r, sum_g, sum_b} !== exp || nd !== 1) begin
      n_err++; $display("FAIL b2b_first: sums %0d/%0d/%0d dones %0d want %0d/%0d/%0d dones 1",
                        sum_r, sum_g, sum_b, nd, exp[119:80], exp[79:40], exp[39:0]);
    end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin pa[i] = 24'($urandom); pb[i] = 24'($urandom); end
    exp = model(5);
    run_frame(5, 1, 1'b0, ok, lat, nd, nr);
    if ({sum_r, sum_g, sum_b} !== exp || nd !== 1) begin
      n_err++; $display("FAIL b2b_second: sums %0d/%0d/%0d dones %0d want %0d/%0d/%0d dones 1",
                        sum_r, sum_g, sum_b, nd, exp[119:80], exp[79:40], exp[39:0]);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    bit ok; int lat, nd, nr; int d0;
    gnt_rand = 1'b1; lat_max = 8;
    for (int i = 0; i < 16; i++) begin pa[i] = 24'($urandom); pb[i] = 24'($urandom); end
    @(negedge clk);
    width = 12'd4; height = 12'd4; start = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    if ({busy, rd_req} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre: busy/req=%b want 11", {busy, rd_req}); end
    n_cmp++;
    rst = 1'b1;
    #1;
    if ({busy, rd_req, done} !== 3'b000 || rd_addr !== 24'd0 || {sum_r, sum_g, sum_b} !== 120'd0) begin
      n_err++; $display("FAIL rstmid_abort: busy/req/done=%b addr=%0d sum_r=%0d want 000/0/0",
                        {busy, rd_req, done}, rd_addr, sum_r);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    inject = 1'b1;
    repeat (3) @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    if (done_cnt !== d0) begin n_err++; $display("FAIL rstmid_no_done: %0d pulses want 0", done_cnt - d0); end
    n_cmp++;
    gnt_rand = 1'b0; lat_max = 1;
    pa[0] = 24'h010203; pb[0] = 24'h000000;
    run_frame(1, 1, 1'b0, ok, lat, nd, nr);
    if ({sum_r, sum_g, sum_b} !== {40'd1, 40'd4, 40'd9}) begin
      n_err++; $display("FAIL rstmid_sums: got %0d/%0d/%0d want 1/4/9", sum_r, sum_g, sum_b);
    end
    n_cmp++;
    if (nd !== 1) begin n_err++; $display("FAIL rstmid_done_count: got %0d want 1", nd); end
    n_cmp++;
  endtask

`ifdef PIX_CMP_MAX_ERR_EN
  task automatic test_max_err();
    bit ok; int lat, nd, nr;
    gnt_rand = 1'b0; lat_max = 2;
    pa[0] = {8'd3, 8'd10, 8'd7};   pb[0] = {8'd0, 8'd0, 8'd7};
    pa[1] = {8'd200, 8'd5, 8'd9};  pb[1] = {8'd0, 8'd0, 8'd9};
    run_frame(2, 1, 1'b0, ok, lat, nd, nr);
    if ({max_r, max_g, max_b} !== {8'd200, 8'd10, 8'd0}) begin
      n_err++; $display("FAIL max_err: got %0d/%0d/%0d want 200/10/0", max_r, max_g, max_b);
    end
    n_cmp++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin pa[i] = '0; pb[i] = '0; end
    test_reset();
    test_basic();
    test_zero_dim();
    test_identical();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef PIX_CMP_MAX_ERR_EN
    test_max_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
